// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolution, data-memory load/store
// handshake with timeout, and the MEM/WB pipeline register.
module mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int RD_W    = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    input  logic            br_in,
    input  logic [31:0]     alu_in,
    input  logic [31:0]     adder_in,
    input  logic [31:0]     imm_in,
    input  logic [RD_W-1:0] rd_in,
    input  logic            mem_rd_in,
    input  logic            mem_wr_in,
    input  logic            reg_wr_in,
    output logic            stall,
    output logic            pc_src,
    output logic [31:0]     branch_target,
    output logic            mem_req,
    output logic            mem_we,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    input  logic            mem_ack,
    input  logic [31:0]     mem_rdata,
    output logic            wb_valid,
    output logic            wb_reg_wr,
    output logic [31:0]     wb_data,
    output logic [RD_W-1:0] wb_rd,
    output logic            err_timeout,
    output logic            err_misalign
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [RD_W-1:0]  rd_q, rd_d;
    logic             rw_q, rw_d;
    logic             ld_q, ld_d;

    logic             wb_valid_q, wb_valid_d;
    logic             wb_reg_wr_q, wb_reg_wr_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [RD_W-1:0]  wb_rd_q, wb_rd_d;
    logic             err_tmo_q, err_tmo_d;
    logic             err_mis_q, err_mis_d;

    logic memop;
    logic aligned;
    logic busy;
    logic start;
    logic expire;
    logic waiting;

    assign memop   = valid_in & (mem_rd_in | mem_wr_in);
    assign aligned = (alu_in[1:0] == 2'b00);
    assign busy    = (state_q == BUSY);
    assign start   = !busy & memop & aligned;
    assign expire  = busy & !mem_ack & (cnt_q == CNT_MAX);
    assign waiting = busy & !mem_ack & (cnt_q < CNT_MAX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = BUSY;
            BUSY: if (mem_ack || expire) state_d = IDLE;
        endcase
    end

    // Outputs and datapath next values
    always_comb begin
        stall       = start | waiting;
        pc_src      = valid_in & br_in & !(start | waiting);
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        rw_d        = rw_q;
        ld_d        = ld_q;
        wb_valid_d  = 1'b0;
        wb_reg_wr_d = 1'b0;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        err_tmo_d   = err_tmo_q;
        err_mis_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    we_d    = mem_wr_in;
                    addr_d  = alu_in;
                    wdata_d = imm_in;
                    rd_d    = rd_in;
                    rw_d    = reg_wr_in;
                    ld_d    = mem_rd_in;
                end else if (valid_in) begin
                    // Misaligned memops retire as non-writing instructions
                    wb_valid_d  = 1'b1;
                    wb_reg_wr_d = reg_wr_in & !memop;
                    wb_data_d   = alu_in;
                    wb_rd_d     = rd_in;
                    err_mis_d   = memop;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    req_d       = 1'b0;
                    wb_valid_d  = 1'b1;
                    wb_reg_wr_d = ld_q & rw_q;
                    wb_data_d   = ld_q ? mem_rdata : addr_q;
                    wb_rd_d     = rd_q;
                end else if (expire) begin
                    req_d      = 1'b0;
                    err_tmo_d  = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_data_d  = addr_q;
                    wb_rd_d    = rd_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= '0;
            rw_q        <= 1'b0;
            ld_q        <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_reg_wr_q <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            err_tmo_q   <= 1'b0;
            err_mis_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            rw_q        <= rw_d;
            ld_q        <= ld_d;
            wb_valid_q  <= wb_valid_d;
            wb_reg_wr_q <= wb_reg_wr_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            err_tmo_q   <= err_tmo_d;
            err_mis_q   <= err_mis_d;
        end
    end

    assign branch_target = adder_in;
    assign mem_req       = req_q;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_reg_wr     = wb_reg_wr_q;
    assign wb_data       = wb_data_q;
    assign wb_rd         = wb_rd_q;
    assign err_timeout   = err_tmo_q;
    assign err_misalign  = err_mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomised scoreboard bench for mem_stage with a transaction-level
// model of the instruction stream and a latency-programmable memory.
module tb_mem_stage;

    localparam int T  = 4;
    localparam int RW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_in, br_in, mem_rd_in, mem_wr_in, reg_wr_in;
    logic [31:0]   alu_in, adder_in, imm_in;
    logic [RW-1:0] rd_in;
    logic          stall, pc_src, mem_req, mem_we, mem_ack;
    logic [31:0]   branch_target, mem_addr, mem_wdata, mem_rdata;
    logic          wb_valid, wb_reg_wr, err_timeout, err_misalign;
    logic [31:0]   wb_data;
    logic [RW-1:0] wb_rd;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT(T), .RD_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .br_in(br_in),
        .alu_in(alu_in), .adder_in(adder_in), .imm_in(imm_in),
        .rd_in(rd_in), .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in),
        .reg_wr_in(reg_wr_in), .stall(stall), .pc_src(pc_src),
        .branch_target(branch_target), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_reg_wr(wb_reg_wr),
        .wb_data(wb_data), .wb_rd(wb_rd), .err_timeout(err_timeout),
        .err_misalign(err_misalign)
    );

    typedef struct {
        logic          reg_wr;
        logic [31:0]   data;
        logic [RW-1:0] rd;
        bit            chk;
        bit            mis;
        bit            tmo;
    } wb_t;

    wb_t         sb[$];
    int          nvec = 0;
    int          nerr = 0;
    bit          tmo_seen = 0;
    bit          skip_req = 0;
    int          cfg_lat = 1;
    int          cfg_exp_req = 0;
    logic [31:0] cfg_addr = '0, cfg_wdata = '0, cfg_rdata = '0;
    logic        cfg_we = 1'b0;
    logic [31:0] dmem [logic [31:0]];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Memory: acks on the programmed BUSY cycle, random acks while idle
    initial begin : resp
        int busy;
        int lat_l;
        int exp_l;
        logic [31:0] a_l, w_l, r_l;
        logic we_l;
        busy = 0; lat_l = 0; exp_l = 0;
        a_l = '0; w_l = '0; r_l = '0; we_l = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (mem_req) begin
                busy++;
                if (busy == 1) begin
                    lat_l = cfg_lat; exp_l = cfg_exp_req;
                    a_l = cfg_addr; w_l = cfg_wdata;
                    r_l = cfg_rdata; we_l = cfg_we;
                end
                chk("mem_addr", mem_addr, a_l);
                chk("mem_we", 32'(mem_we), 32'(we_l));
                chk("mem_wdata", mem_wdata, w_l);
                mem_ack = (busy == lat_l);
                mem_rdata = mem_ack ? r_l : $urandom;
            end else begin
                if (busy != 0 && !skip_req)
                    chk("req_cycles", 32'(busy), 32'(exp_l));
                busy = 0;
                mem_ack = ($urandom_range(3) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Scoreboard monitor
    initial begin : mon
        wb_t r;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wb_valid) begin
                    if (sb.size() == 0) begin
                        nvec++; nerr++;
                        $display("FAIL wb_unexpected: got wb_valid=1 want none");
                    end else begin
                        r = sb.pop_front();
                        chk("wb_reg_wr", 32'(wb_reg_wr), 32'(r.reg_wr));
                        if (r.chk) begin
                            chk("wb_data", wb_data, r.data);
                            chk("wb_rd", 32'(wb_rd), 32'(r.rd));
                        end
                        chk("err_misalign", 32'(err_misalign), 32'(r.mis));
                        tmo_seen = tmo_seen | r.tmo;
                        chk("err_timeout", 32'(err_timeout), 32'(tmo_seen));
                    end
                end else begin
                    chk("bubble_reg_wr", 32'(wb_reg_wr), 32'd0);
                    chk("bubble_misalign", 32'(err_misalign), 32'd0);
                end
            end
        end
    end

    task automatic issue(input bit v, input bit br, input bit rop,
                         input bit wop, input bit rw,
                         input logic [31:0] alu, input logic [31:0] adder,
                         input logic [31:0] imm, input logic [RW-1:0] rd,
                         input int lat);
        wb_t r;
        bit memop;
        int n;
        int sc;
        logic [31:0] rdv;
        memop = v && (rop || wop);
        n = 0;
        r = '{reg_wr: 1'b0, data: alu, rd: rd, chk: 1'b0, mis: 1'b0, tmo: 1'b0};
        if (v && !memop) begin
            r.reg_wr = rw; r.chk = 1'b1;
            sb.push_back(r);
        end else if (memop && alu[1:0] != 2'b00) begin
            r.mis = 1'b1;
            sb.push_back(r);
        end else if (memop) begin
            n = (lat < T) ? lat : T;
            rdv = dmem.exists(alu) ? dmem[alu] : $urandom;
            cfg_lat = lat; cfg_exp_req = n; cfg_addr = alu;
            cfg_we = wop; cfg_wdata = imm; cfg_rdata = rdv;
            if (lat <= T) begin
                r.chk = 1'b1;
                if (rop) begin
                    r.reg_wr = rw; r.data = rdv; dmem[alu] = rdv;
                end else begin
                    dmem[alu] = imm;
                end
            end else begin
                r.tmo = 1'b1;
            end
            sb.push_back(r);
        end
        @(posedge clk); #1;
        valid_in = v; br_in = br; mem_rd_in = rop; mem_wr_in = wop;
        reg_wr_in = rw; alu_in = alu; adder_in = adder; imm_in = imm;
        rd_in = rd;
        sc = 0;
        @(negedge clk);
        chk("pc_src", 32'(pc_src), 32'(v && br && (n == 0)));
        chk("branch_target", branch_target, adder);
        while (stall && sc < 60) begin
            sc++;
            @(negedge clk);
        end
        chk("stall_cycles", 32'(sc), 32'(n));
    endtask

    initial begin : drv
        int k;
        bit rop, wop, v;
        logic [31:0] a;
        rst_n = 1'b0;
        valid_in = 0; br_in = 0; mem_rd_in = 0; mem_wr_in = 0;
        reg_wr_in = 0; alu_in = '0; adder_in = '0; imm_in = '0; rd_in = '0;
        #12;
        valid_in = 1; mem_rd_in = 1; alu_in = 32'h40;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
        chk("rst_err_misalign", 32'(err_misalign), 32'd0);
        chk("rst_stall_idle_eq", 32'(stall), 32'd1);
        valid_in = 0; mem_rd_in = 0; alu_in = '0;
        @(negedge clk); rst_n = 1'b1;

        dmem[32'h100] = 32'hDEAD_BEEF;
        issue(1, 0, 0, 0, 1, 32'h1234, 32'h0, 32'h0, 6'd5, 0);
        issue(1, 0, 1, 0, 1, 32'h100, 32'h0, 32'h0, 6'd9, 3);
        issue(1, 0, 0, 1, 0, 32'h200, 32'h0, 32'hCAFE, 6'd3, 1);
        issue(1, 0, 1, 0, 1, 32'h300, 32'h0, 32'h0, 6'd4, 99);
        issue(1, 0, 0, 0, 1, 32'h55, 32'h0, 32'h0, 6'd6, 0);
        issue(1, 0, 1, 0, 1, 32'h102, 32'h0, 32'h0, 6'd7, 1);
        issue(1, 1, 0, 0, 0, 32'h0, 32'h400, 32'h0, 6'd0, 0);
        issue(1, 0, 0, 1, 0, 32'h204, 32'h0, 32'h77, 6'd2, T);

        // Abort an in-flight load with reset
        cfg_lat = 1000; cfg_addr = 32'h40; cfg_we = 0;
        cfg_wdata = 32'h0; cfg_rdata = 32'h0; skip_req = 1;
        @(posedge clk); #1;
        valid_in = 1; mem_rd_in = 1; mem_wr_in = 0; alu_in = 32'h40;
        rd_in = 6'd7; reg_wr_in = 1; imm_in = 32'h0; br_in = 0;
        repeat (3) @(posedge clk);
        #3;
        chk("abort_req_pre", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_wb_valid", 32'(wb_valid), 32'd0);
        chk("abort_err_timeout", 32'(err_timeout), 32'd0);
        sb.delete();
        tmo_seen = 0;
        valid_in = 0; mem_rd_in = 0;
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #3; skip_req = 0;
        issue(1, 0, 1, 0, 1, 32'h100, 32'h0, 32'h0, 6'd11, 2);

        for (int i = 0; i < 200; i++) begin
            k = $urandom_range(9);
            v = (k != 0);
            rop = (k >= 5 && k <= 7) || (k == 0 && $urandom_range(1) == 1);
            wop = (k >= 8);
            a = 32'h1000 | (32'($urandom_range(15)) << 2);
            if ((rop || wop) && $urandom_range(5) == 0)
                a = a | 32'($urandom_range(3, 1));
            if (!(rop || wop) && v) a = $urandom;
            issue(v, (k >= 1 && k <= 4) && ($urandom_range(1) == 1),
                  rop, wop, 1'($urandom_range(1)), a, $urandom, $urandom,
                  RW'($urandom), $urandom_range(T + 2, 1));
        end

        issue(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 6'd0, 0);
        repeat (4) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
